// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute
// with instruction-field decode of ALU control and immediate format.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] State
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  state_t r_state;
  aluop_t w_aluop;
  logic   w_pc_update;
  logic   w_branch;
  logic   w_mem_write;
  logic   w_ir_write;
  logic   w_reg_write;

  // State register with next-state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECUTER;
            OP_I:         r_state <= S_EXECUTEI;
            OP_BEQ:       r_state <= S_BEQ;
            OP_JAL:       r_state <= S_JAL;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        S_JAL:      r_state <= S_ALUWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the current state
  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_aluop     = ALU_ADD;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        w_aluop = ALU_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_aluop = ALU_FUNCT;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_aluop  = ALU_SUB;
        w_branch = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU operation from ALUOp and instruction fields
  always_comb begin
    ALUControl = 3'b000;
    case (w_aluop)
      ALU_SUB: ALUControl = 3'b001;
      ALU_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Strobes are held off while reset is asserted so an aborted instruction commits nothing
  assign PCWrite  = (w_pc_update | (w_branch & zero)) & ~reset;
  assign IRWrite  = w_ir_write  & ~reset;
  assign MemWrite = w_mem_write & ~reset;
  assign RegWrite = w_reg_write & ~reset;
  assign State    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-level model of state sequences and
// per-state control values, checked every cycle, plus literal spot checks.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw;
    logic [3:0] st;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rst;
  } item_t;

  typedef int iq_t[$];

  item_t exp_q[$];

  // Expected state walk for a whole instruction, from its class
  function automatic iq_t model_seq(input logic [6:0] o);
    iq_t s;
    case (o)
      7'b0000011: s = '{0, 1, 2, 3, 4};
      7'b0100011: s = '{0, 1, 2, 5};
      7'b0110011: s = '{0, 1, 6, 8};
      7'b0010011: s = '{0, 1, 7, 8};
      7'b1100011: s = '{0, 1, 9};
      7'b1101111: s = '{0, 1, 10, 8};
      default:    s = '{0, 1};
    endcase
    return s;
  endfunction

  function automatic logic [2:0] model_alu(input int aop, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7);
    if (aop == 0) return 3'b000;
    if (aop == 1) return 3'b001;
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Control values the state table requires, given current inputs
  function automatic outs_t model_out(input logic [3:0] st, input logic rst,
                                      input logic [6:0] o, input logic [2:0] f3,
                                      input logic f7, input logic z);
    outs_t e;
    int    aop;
    logic  pcu, br;
    e = '0; aop = 0; pcu = 1'b0; br = 1'b0;
    case (st)
      4'd0:  begin e.irw = 1; e.sb = 2'b10; e.rs = 2'b10; pcu = 1; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  e.adr = 1;
      4'd4:  begin e.rs = 2'b01; e.rw = 1; end
      4'd5:  begin e.adr = 1; e.mw = 1; end
      4'd6:  begin e.sa = 2'b10; aop = 2; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; aop = 2; end
      4'd8:  e.rw = 1;
      4'd9:  begin e.sa = 2'b10; aop = 1; br = 1; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; pcu = 1; end
      default: ;
    endcase
    e.pcw = pcu | (br & z);
    e.alu = model_alu(aop, o, f3, f7);
    e.imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
            (o == 7'b1101111) ? 2'b11 : 2'b00;
    if (rst) begin e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0; end
    e.st = st;
    return e;
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      outs_t e, a;
      it = exp_q.pop_front();
      e  = model_out(it.st, it.rst, op, funct3, funct7b5, zero);
      a  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUControl, ImmSrc, RegWrite, State};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle op=%b state_exp=%0d actual=%h required=%h (pcw,adr,mw,irw,rs,sa,sb,alu,imm,rw,st)",
                 op, it.st, a, e);
      end
    end
  end

  task automatic lit_check(input string name, input int field, input logic [3:0] want);
    logic [3:0] got;
    case (field)
      0: got = State;
      1: got = 4'(PCWrite);
      2: got = 4'(MemWrite);
      3: got = 4'(RegWrite);
      4: got = 4'(ALUControl);
      5: got = 4'(ImmSrc);
      default: got = 4'(ResultSrc);
    endcase
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, got, want);
    end
  endtask

  // Runs one instruction; optional reset pulse at step 'abort', literal check at 'lstep'
  task automatic run_instr(input string name, input logic [6:0] t_op, input logic [2:0] t_f3,
                           input logic t_f7, input logic t_z, input int abort,
                           input int lstep, input int lfield, input logic [3:0] lval);
    iq_t seq;
    item_t it;
    seq = model_seq(t_op);
    op = t_op; funct3 = t_f3; funct7b5 = t_f7; zero = t_z;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort) reset = 1'b1;
      it.st  = 4'(seq[i]);
      it.rst = (i == abort);
      exp_q.push_back(it);
      @(negedge clk);
      if (i == lstep) lit_check(name, lfield, lval);
      @(posedge clk); #1;
      if (i == abort) begin
        reset = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it;
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    it.st = 4'd0; it.rst = 1'b1;
    exp_q.push_back(it);
    @(negedge clk);
    lit_check("reset_state", 0, 4'd0);
    lit_check("reset_pcwrite", 1, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr("lw_regwrite",  7'b0000011, 3'b010, 1'b0, 1'b0, -1, 4, 3, 4'd1);
    run_instr("sw_memwrite",  7'b0100011, 3'b010, 1'b0, 1'b0, -1, 3, 2, 4'd1);
    run_instr("sw_immsrc",    7'b0100011, 3'b010, 1'b0, 1'b1, -1, 0, 5, 4'd1);
    run_instr("r_sub_alu",    7'b0110011, 3'b000, 1'b1, 1'b0, -1, 2, 4, 4'd1);
    run_instr("addi_alu",     7'b0010011, 3'b000, 1'b1, 1'b0, -1, 2, 4, 4'd0);
    run_instr("slt_alu",      7'b0110011, 3'b010, 1'b0, 1'b0, -1, 2, 4, 4'd5);
    run_instr("ori_alu",      7'b0010011, 3'b110, 1'b0, 1'b1, -1, 2, 4, 4'd3);
    run_instr("and_alu",      7'b0110011, 3'b111, 1'b0, 1'b0, -1, 2, 4, 4'd2);
    run_instr("sll_alu",      7'b0110011, 3'b001, 1'b1, 1'b0, -1, 2, 4, 4'd0);
    run_instr("beq_taken",    7'b1100011, 3'b000, 1'b0, 1'b1, -1, 2, 1, 4'd1);
    run_instr("beq_nottaken", 7'b1100011, 3'b000, 1'b0, 1'b0, -1, 2, 1, 4'd0);
    run_instr("jal_pcwrite",  7'b1101111, 3'b000, 1'b0, 1'b0, -1, 2, 1, 4'd1);
    run_instr("jal_immsrc",   7'b1101111, 3'b000, 1'b0, 1'b0, -1, 3, 5, 4'd3);
    run_instr("bad_op_decode",7'b1111111, 3'b000, 1'b0, 1'b1, -1, 1, 0, 4'd1);
    run_instr("sw_abort",     7'b0100011, 3'b010, 1'b0, 1'b0,  3, 3, 2, 4'd0);
    run_instr("r_abort",      7'b0110011, 3'b000, 1'b0, 1'b0,  3, 3, 3, 4'd0);
    run_instr("lw_after",     7'b0000011, 3'b010, 1'b0, 1'b0, -1, 4, 6, 4'd1);

    it.st = 4'd0; it.rst = 1'b0;
    exp_q.push_back(it);
    @(negedge clk);
    lit_check("final_fetch", 0, 4'd0);
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
